bus_xfer_ctrl: RTL

- Stage directly downstream of the 4-way round-robin arbiter.
- Consumes the arbiter's registered one-hot grant and routes the granted requester's burst (address, write data, direction, length) onto the single shared slave bus.
- Returns per-requester beat acknowledges and read data, then a one-cycle done pulse; the requester then drops req so the arbiter can rotate.

---
 rtl/bus_xfer_ctrl_pkg.sv | 30 +++
 rtl/bus_xfer_mux.sv | 26 ++
 rtl/bus_xfer_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and helpers for the bus transfer stage.
// Holds the FSM state encoding, requester count and grant decode helpers.
package bus_xfer_ctrl_pkg;

    localparam int NREQ = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // True when exactly one grant bit is set.
    function automatic logic is_onehot(input logic [NREQ-1:0] oh);
        return (oh != '0) && ((oh & (oh - 1'b1)) == '0);
    endfunction

    // Index of the set bit; meaningful only for a one-hot input.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) r = i[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_xfer_mux.sv
// Combinational 4:1 selector of one requester's burst fields.
// Ports: sel picks requester; packed addr/wdata/we/len in, selected fields out.
module bus_xfer_mux
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int LENW = 4
) (
    input  logic [1:0]           sel,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [AW-1:0]        addr,
    output logic [DW-1:0]        wdata,
    output logic                 we,
    output logic [LENW-1:0]      len
);

    assign addr  = req_addr[sel*AW +: AW];
    assign wdata = req_wdata[sel*DW +: DW];
    assign we    = req_we[sel];
    assign len   = req_len[sel*LENW +: LENW];

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Routes the granted requester's burst onto the shared slave bus.
// Ports: gnt/req_* from arbiter side, beat_ack/done/m_rdata back,
// s_* slave bus, busy and err status.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int LENW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      gnt,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      beat_ack,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        m_rdata,
    output logic                 s_valid,
    output logic                 s_we,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    input  logic                 s_ready,
    input  logic                 s_rvalid,
    input  logic [DW-1:0]        s_rdata,
    output logic                 busy,
    output logic                 err
);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      idx;
    logic [1:0]      gnt_idx;
    logic [1:0]      sel;
    logic [AW-1:0]   addr;
    logic [LENW-1:0] cnt;
    logic [NREQ-1:0] idx_oh;
    logic [NREQ-1:0] rd_ack;
    logic [NREQ-1:0] rd_done;
    logic [AW-1:0]   mux_addr;
    logic [DW-1:0]   mux_wdata;
    logic            mux_we;
    logic [LENW-1:0] mux_len;
    logic            gnt_held;
    logic            last;
    logic            start;
    logic            beat;
    logic            rd_cap;
    logic            wr_ack;
    logic            wr_done;

    // In IDLE look at the incoming grant; afterwards stick to the latched one.
    assign gnt_idx  = onehot_to_idx(gnt);
    assign sel      = (state == IDLE) ? gnt_idx : idx;
    assign idx_oh   = 4'b0001 << idx;
    assign gnt_held = gnt[idx];
    assign last     = (cnt == '0);

    bus_xfer_mux #(
        .AW   (AW),
        .DW   (DW),
        .LENW (LENW)
    ) u_mux (
        .sel       (sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_len   (req_len),
        .addr      (mux_addr),
        .wdata     (mux_wdata),
        .we        (mux_we),
        .len       (mux_len)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            addr    <= '0;
            cnt     <= '0;
            m_rdata <= '0;
            rd_ack  <= '0;
            rd_done <= '0;
        end else begin
            state   <= state_nxt;
            rd_ack  <= rd_cap ? idx_oh : '0;
            rd_done <= (rd_cap && last) ? idx_oh : '0;
            if (rd_cap) m_rdata <= s_rdata;
            if (start) begin
                idx  <= gnt_idx;
                addr <= mux_addr;
                cnt  <= mux_len;
            end else if (beat) begin
                addr <= addr + 1'b1;
                cnt  <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s_valid   = 1'b0;
        s_we      = 1'b0;
        start     = 1'b0;
        beat      = 1'b0;
        rd_cap    = 1'b0;
        wr_ack    = 1'b0;
        wr_done   = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt != '0) begin
                    if (is_onehot(gnt)) begin
                        start     = 1'b1;
                        state_nxt = mux_we ? WR : RD_REQ;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            WR: begin
                s_valid = 1'b1;
                s_we    = 1'b1;
                if (s_ready) begin
                    beat   = 1'b1;
                    wr_ack = 1'b1;
                end
                // A final beat landing with the grant already gone still completes.
                if (s_ready && last) begin
                    wr_done   = 1'b1;
                    state_nxt = RELEASE;
                end else if (!gnt_held) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                s_valid = 1'b1;
                if (!gnt_held) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (s_ready) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (s_rvalid) begin
                    beat   = 1'b1;
                    rd_cap = 1'b1;
                end
                if (s_rvalid && last) begin
                    state_nxt = RELEASE;
                end else if (!gnt_held) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (s_rvalid) begin
                    state_nxt = RD_REQ;
                end
            end
            RELEASE: begin
                // Registered grant may still point here; wait for it to clear.
                if (!gnt_held) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write acks are same-cycle; read acks align with registered m_rdata.
    assign beat_ack = ({NREQ{wr_ack}} & idx_oh) | rd_ack;
    assign done     = ({NREQ{wr_done}} & idx_oh) | rd_done;
    assign s_addr   = addr;
    assign s_wdata  = (state == WR) ? mux_wdata : '0;
    assign busy     = (state != IDLE);

endmodule
